// File: rtl/tdc_ram_readout_if.sv
// Bundles the RAM read port and the host byte stream used by tdc_ram_readout.
// The master side is the readout engine; the slave side is the RAM plus host link.
interface tdc_ram_readout_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [15:0]           ram_data;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output ram_rd_en, ram_addr, tx_data, tx_valid,
        input  ram_data, tx_ready
    );

    modport slave (
        input  ram_rd_en, ram_addr, tx_data, tx_valid,
        output ram_data, tx_ready
    );
endinterface

// File: rtl/tdc_ram_readout.sv
// Walks the TDC records in base-board RAM (two 16-bit words each), checks the
// padding field and streams each record to the host as a 5-byte frame plus trailer.
module tdc_ram_readout #(
    parameter int ADDR_WIDTH = 10,
    parameter int N_TDC      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_readout,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  format_error,
    tdc_ram_readout_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_W0,
        RD_W1,
        CAPTURE,
        SEND,
        TRAILER,
        DONE
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(N_TDC - 1);

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [2:0]            bcnt_q, bcnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [6:0]            dout_q, dout_d;
    logic [4:0]            saff_hi_q, saff_hi_d;
    logic [15:0]           saff_lo_q, saff_lo_d;
    logic                  fmt_err_q, fmt_err_d;

    logic                  rd_en_c;
    logic                  tx_valid_c;
    logic [7:0]            tx_data_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            bcnt_q    <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            saff_hi_q <= '0;
            saff_lo_q <= '0;
            fmt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            saff_hi_q <= saff_hi_d;
            saff_lo_q <= saff_lo_d;
            fmt_err_q <= fmt_err_d;
        end
    end

    // Records are contiguous, so the address always just steps by one word;
    // word1 + 1 of one record is word0 of the next.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        saff_hi_d  = saff_hi_q;
        saff_lo_d  = saff_lo_q;
        fmt_err_d  = fmt_err_q;
        rd_en_c    = 1'b0;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;

        case (state_q)
            IDLE: begin
                if (start_readout) begin
                    state_d   = RD_W0;
                    addr_d    = base_addr;
                    idx_d     = '0;
                    bcnt_d    = '0;
                    fmt_err_d = 1'b0;
                end
            end
            RD_W0: begin
                rd_en_c = 1'b1;
                addr_d  = addr_q + 1'b1;
                state_d = RD_W1;
            end
            RD_W1: begin
                rd_en_c   = 1'b1;
                dout_d    = bus.ram_data[15:9];
                saff_hi_d = bus.ram_data[4:0];
                if (bus.ram_data[8:5] != 4'b0000) begin
                    fmt_err_d = 1'b1;
                end
                state_d = CAPTURE;
            end
            CAPTURE: begin
                saff_lo_d = bus.ram_data;
                bcnt_d    = '0;
                state_d   = SEND;
            end
            SEND: begin
                tx_valid_c = 1'b1;
                case (bcnt_q)
                    3'd0:    tx_data_c = {5'b10100, idx_q};
                    3'd1:    tx_data_c = {1'b0, dout_q};
                    3'd2:    tx_data_c = {3'b000, saff_hi_q};
                    3'd3:    tx_data_c = saff_lo_q[15:8];
                    default: tx_data_c = saff_lo_q[7:0];
                endcase
                if (bus.tx_ready) begin
                    if (bcnt_q == 3'd4) begin
                        bcnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = TRAILER;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            addr_d  = addr_q + 1'b1;
                            state_d = RD_W0;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            TRAILER: begin
                tx_valid_c = 1'b1;
                tx_data_c  = 8'h55;
                if (bus.tx_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ram_rd_en = rd_en_c;
    assign bus.ram_addr  = addr_q;
    assign bus.tx_valid  = tx_valid_c;
    assign bus.tx_data   = tx_data_c;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign format_error  = fmt_err_q;

endmodule

// File: tb/tb_tdc_ram_readout.sv
// Randomized bench for tdc_ram_readout: a RAM model, a byte/address monitor and
// a record-level reference model that predicts the framed byte stream.
module tb_tdc_ram_readout;

    localparam int AW = 10;
    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_readout = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy;
    logic          done;
    logic          format_error;

    tdc_ram_readout_if #(.ADDR_WIDTH(AW)) bus_if ();

    tdc_ram_readout #(.ADDR_WIDTH(AW), .N_TDC(NT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_readout(start_readout),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
        .format_error (format_error),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    logic [15:0]   mem [0:(1<<AW)-1];
    logic [7:0]    rx_q[$];
    logic [7:0]    exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic          exp_err;

    int total = 0;
    int bad = 0;
    int xfer_cnt = 0;
    int stab_err = 0;
    int done_cnt = 0;
    int ready_mode = 0;
    int stall_left = 0;
    int stalled_at = -1;
    logic       hold_pending = 1'b0;
    logic [7:0] held_data = 8'h00;

    // RAM read port: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (bus_if.ram_rd_en === 1'b1) bus_if.ram_data <= mem[bus_if.ram_addr];
    end

    // Records transfers, RAM reads, done pulses and any stall-time instability
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending && (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== held_data))
                stab_err++;
            hold_pending = (bus_if.tx_valid === 1'b1) && (bus_if.tx_ready === 1'b0);
            held_data = bus_if.tx_data;
            if (bus_if.tx_valid === 1'b1 && bus_if.tx_ready === 1'b1) begin
                rx_q.push_back(bus_if.tx_data);
                xfer_cnt++;
            end
            if (bus_if.ram_rd_en === 1'b1) addr_q.push_back(bus_if.ram_addr);
            if (done === 1'b1) done_cnt++;
        end
    end

    // Host link: always ready, or random with 10-cycle stalls on header/trailer bytes
    initial begin
        bus_if.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_mode == 0) begin
                bus_if.tx_ready = 1'b1;
            end else if (stall_left > 0) begin
                bus_if.tx_ready = 1'b0;
                stall_left--;
            end else if (bus_if.tx_valid === 1'b1 && stalled_at != xfer_cnt &&
                         (bus_if.tx_data == 8'h55 || bus_if.tx_data[7:3] == 5'b10100)) begin
                stalled_at = xfer_cnt;
                stall_left = 9;
                bus_if.tx_ready = 1'b0;
            end else begin
                bus_if.tx_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom) & 16'hFE1F;
    endtask

    // Reference: record i lives at base+2i / base+2i+1 (mod RAM size)
    task automatic build_expected(input logic [AW-1:0] base);
        logic [AW-1:0] a0;
        logic [15:0]   w0, w1;
        exp_q.delete();
        exp_addr_q.delete();
        exp_err = 1'b0;
        for (int i = 0; i < NT; i++) begin
            a0 = AW'(int'(base) + 2 * i);
            w0 = mem[a0];
            w1 = mem[AW'(a0 + 1)];
            exp_addr_q.push_back(a0);
            exp_addr_q.push_back(AW'(a0 + 1));
            exp_q.push_back(8'hA0 | 8'(i));
            exp_q.push_back({1'b0, w0[15:9]});
            exp_q.push_back({3'b000, w0[4:0]});
            exp_q.push_back(w1[15:8]);
            exp_q.push_back(w1[7:0]);
            if (w0[8:5] != 4'b0000) exp_err = 1'b1;
        end
        exp_q.push_back(8'h55);
    endtask

    function automatic int stream_diff();
        int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) if (rx_q[k] !== exp_q[k]) return k;
        return (rx_q.size() == exp_q.size()) ? -1 : n;
    endfunction

    function automatic int addr_diff();
        int n = (addr_q.size() < exp_addr_q.size()) ? addr_q.size() : exp_addr_q.size();
        for (int k = 0; k < n; k++) if (addr_q[k] !== exp_addr_q[k]) return k;
        return (addr_q.size() == exp_addr_q.size()) ? -1 : n;
    endfunction

    function automatic logic [7:0] rx_at(input int k);
        return (k < rx_q.size()) ? rx_q[k] : 8'hxx;
    endfunction

    // Runs one readout; cycle 1 is the cycle right after the start edge.
    // done_cyc = -1 means the cycle budget ran out.
    task automatic do_frame(input logic [AW-1:0] base, input int poke, input int budget,
                            output int done_cyc, output int first_valid);
        int cyc;
        rx_q.delete();
        addr_q.delete();
        done_cnt = 0;
        stab_err = 0;
        done_cyc = -1;
        first_valid = -1;
        @(negedge clk);
        base_addr = base;
        start_readout = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_readout = 1'b0;
        cyc = 1;
        while (cyc <= budget) begin
            if (first_valid < 0 && bus_if.tx_valid === 1'b1) first_valid = cyc;
            start_readout = (cyc == poke);
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start_readout = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus_if.ram_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_en got=%b want=0", bus_if.ram_rd_en); end
        total++; if (bus_if.ram_addr !== '0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=000", bus_if.ram_addr); end
        total++; if (bus_if.tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_tx_data got=%h want=00", bus_if.tx_data); end
        total++; if (bus_if.tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_valid got=%b want=0", bus_if.tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        total++; if (format_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_format_error got=%b want=0", format_error); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || bus_if.tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset busy=%b tx_valid=%b want 0/0", busy, bus_if.tx_valid); end
    endtask

    task automatic test_single_record();
        int dc, fv, d;
        logic [7:0] want [0:4];
        want = '{8'hA0, 8'h5A, 8'h13, 8'hBE, 8'hEF};
        fill_mem();
        mem[0] = 16'hB413;
        mem[1] = 16'hBEEF;
        build_expected(10'h000);
        ready_mode = 0;
        do_frame(10'h000, -1, 200, dc, fv);
        for (int k = 0; k < 5; k++) begin
            total++; if (rx_at(k) !== want[k]) begin bad++; $display("[TB] FAIL single_byte%0d got=%h want=%h", k, rx_at(k), want[k]); end
        end
        total++; if (rx_at(5*NT) !== 8'h55) begin bad++; $display("[TB] FAIL single_trailer got=%h want=55", rx_at(5*NT)); end
        d = stream_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL single_stream diff_at=%0d got_len=%0d want_len=%0d", d, rx_q.size(), exp_q.size()); end
        total++; if (fv != 4) begin bad++; $display("[TB] FAIL first_byte_latency got=%0d want=4", fv); end
        total++; if (dc != 8*NT + 2) begin bad++; $display("[TB] FAIL done_cycle got=%0d want=%0d", dc, 8*NT + 2); end
        total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL done_pulses got=%0d want=1", done_cnt); end
        total++; if (format_error !== 1'b0) begin bad++; $display("[TB] FAIL single_format_error got=%b want=0", format_error); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_after_done got=%b want=0", busy); end
    endtask

    task automatic test_addr_sequence();
        int dc, fv, d;
        fill_mem();
        build_expected(10'h010);
        ready_mode = 0;
        do_frame(10'h010, -1, 200, dc, fv);
        d = addr_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL addr_seq diff_at=%0d got_len=%0d want_len=%0d", d, addr_q.size(), exp_addr_q.size()); end
        d = stream_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL addr_seq_stream diff_at=%0d got_len=%0d want_len=%0d", d, rx_q.size(), exp_q.size()); end
        total++; if (dc != 8*NT + 2) begin bad++; $display("[TB] FAIL addr_seq_done_cycle got=%0d want=%0d", dc, 8*NT + 2); end
    endtask

    task automatic test_backpressure();
        int dc, fv, d;
        for (int r = 0; r < 3; r++) begin
            logic [AW-1:0] base;
            base = AW'($urandom_range(0, (1 << AW) - 1));
            fill_mem();
            build_expected(base);
            ready_mode = 1;
            do_frame(base, -1, 2000, dc, fv);
            ready_mode = 0;
            total++; if (dc < 0) begin bad++; $display("[TB] FAIL bp_timeout run=%0d got=no_done want=done", r); end
            d = stream_diff();
            total++; if (d != -1) begin bad++; $display("[TB] FAIL bp_stream run=%0d diff_at=%0d got_len=%0d want_len=%0d", r, d, rx_q.size(), exp_q.size()); end
            total++; if (stab_err != 0) begin bad++; $display("[TB] FAIL bp_stall_stability run=%0d got=%0d want=0", r, stab_err); end
            total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL bp_done_pulses run=%0d got=%0d want=1", r, done_cnt); end
        end
    endtask

    task automatic test_wrap();
        int dc, fv, d;
        fill_mem();
        build_expected(10'h3FE);
        ready_mode = 0;
        do_frame(10'h3FE, -1, 200, dc, fv);
        d = addr_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL wrap_addr diff_at=%0d got_len=%0d want_len=%0d", d, addr_q.size(), exp_addr_q.size()); end
        total++; if (addr_q.size() < 3 || addr_q[2] !== 10'h000) begin bad++; $display("[TB] FAIL wrap_third_addr got_len=%0d want addr 000", addr_q.size()); end
        d = stream_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL wrap_stream diff_at=%0d got_len=%0d want_len=%0d", d, rx_q.size(), exp_q.size()); end
    endtask

    task automatic test_format_error();
        int dc, fv, d;
        fill_mem();
        mem[0] = 16'hB433;
        build_expected(10'h000);
        ready_mode = 0;
        do_frame(10'h000, -1, 200, dc, fv);
        total++; if (format_error !== exp_err) begin bad++; $display("[TB] FAIL fmt_err_set got=%b want=%b", format_error, exp_err); end
        total++; if (rx_at(1) !== 8'h5A) begin bad++; $display("[TB] FAIL fmt_byte1 got=%h want=5A", rx_at(1)); end
        total++; if (rx_at(2) !== 8'h13) begin bad++; $display("[TB] FAIL fmt_byte2 got=%h want=13", rx_at(2)); end
        d = stream_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL fmt_stream diff_at=%0d got_len=%0d want_len=%0d", d, rx_q.size(), exp_q.size()); end
        repeat (5) @(negedge clk);
        total++; if (format_error !== 1'b1) begin bad++; $display("[TB] FAIL fmt_err_sticky got=%b want=1", format_error); end
        fill_mem();
        build_expected(10'h000);
        do_frame(10'h000, -1, 200, dc, fv);
        total++; if (format_error !== 1'b0) begin bad++; $display("[TB] FAIL fmt_err_cleared got=%b want=0", format_error); end
    endtask

    task automatic test_start_ignored();
        int dc, fv, d;
        logic [AW-1:0] base;
        base = AW'($urandom_range(0, (1 << AW) - 1));
        fill_mem();
        build_expected(base);
        ready_mode = 0;
        do_frame(base, 13, 200, dc, fv);
        total++; if (dc != 8*NT + 2) begin bad++; $display("[TB] FAIL busy_start_done_cycle got=%0d want=%0d", dc, 8*NT + 2); end
        d = stream_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL busy_start_stream diff_at=%0d got_len=%0d want_len=%0d", d, rx_q.size(), exp_q.size()); end
        d = addr_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL busy_start_addr diff_at=%0d got_len=%0d want_len=%0d", d, addr_q.size(), exp_addr_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int dc, fv, d;
        fill_mem();
        mem[10'h100] = mem[10'h100] | 16'h0020;
        ready_mode = 0;
        @(negedge clk);
        base_addr = 10'h100;
        start_readout = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_readout = 1'b0;
        repeat (12) @(negedge clk);
        total++; if (bus_if.tx_valid !== 1'b1 || format_error !== 1'b1) begin bad++; $display("[TB] FAIL mid_frame_pre tx_valid=%b format_error=%b want 1/1", bus_if.tx_valid, format_error); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (bus_if.ram_rd_en !== 1'b0 || bus_if.ram_addr !== '0) begin bad++; $display("[TB] FAIL mid_reset_ram got rd_en=%b addr=%h want 0/000", bus_if.ram_rd_en, bus_if.ram_addr); end
        total++; if (bus_if.tx_valid !== 1'b0 || bus_if.tx_data !== 8'h00) begin bad++; $display("[TB] FAIL mid_reset_tx got valid=%b data=%h want 0/00", bus_if.tx_valid, bus_if.tx_data); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || format_error !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_status got busy=%b done=%b ferr=%b want 0/0/0", busy, done, format_error); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mem[10'h100] = mem[10'h100] & 16'hFE1F;
        build_expected(10'h100);
        do_frame(10'h100, -1, 200, dc, fv);
        d = stream_diff();
        total++; if (d != -1) begin bad++; $display("[TB] FAIL post_reset_stream diff_at=%0d got_len=%0d want_len=%0d", d, rx_q.size(), exp_q.size()); end
        total++; if (dc != 8*NT + 2) begin bad++; $display("[TB] FAIL post_reset_done_cycle got=%0d want=%0d", dc, 8*NT + 2); end
        total++; if (format_error !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_format_error got=%b want=0", format_error); end
    endtask

    initial begin
        $display("[TB] tdc_ram_readout bench start");
        test_reset();
        test_single_record();
        test_addr_sequence();
        test_backpressure();
        test_wrap();
        test_format_error();
        test_start_ignored();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
